// File: rtl/ped_signal_ctrl.sv
// Pedestrian walk/don't-walk controller.
// Follows the vehicle lamp sequencer and serves requests at red entry.
module ped_signal_ctrl #(
  parameter int         WALK_CYCLES  = 6,
  parameter int         FLASH_CYCLES = 4,
  parameter logic [2:0] RED          = 3'b100,
  parameter logic [2:0] YELLOW       = 3'b010,
  parameter logic [2:0] GREEN        = 3'b001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light,
  input  logic       ped_req,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
  output logic [3:0] remaining,
  output logic       abort,
  output logic       fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RED,
    S_WALK,
    S_FLASH
  } state_t;

  localparam logic [3:0] WALK_LAST  = 4'(WALK_CYCLES - 1);
  localparam logic [3:0] FLASH_LAST = 4'(FLASH_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_prev;
  logic       r_walk;
  logic       r_dw;
  logic       r_req;
  logic [3:0] r_rem;
  logic       r_abort;
  logic       r_fault;

  logic       w_walk_nxt;
  logic       w_dw_nxt;
  logic       w_req_nxt;
  logic [3:0] w_rem_nxt;
  logic       w_abort_nxt;
  logic       w_fault_nxt;

  logic w_red;
  logic w_red_entry;
  logic w_legal;
  logic w_pend;

  assign w_red       = (light == RED);
  assign w_red_entry = w_red && (r_prev != RED);
  assign w_legal     = (light == RED) || (light == YELLOW) ||
                       (light == GREEN);
  assign w_pend      = r_req | ped_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_prev  <= RED;
      r_walk  <= 1'b0;
      r_dw    <= 1'b1;
      r_req   <= 1'b0;
      r_rem   <= 4'd0;
      r_abort <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= light;
      r_walk  <= w_walk_nxt;
      r_dw    <= w_dw_nxt;
      r_req   <= w_req_nxt;
      r_rem   <= w_rem_nxt;
      r_abort <= w_abort_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (ped_req) w_state_nxt = S_WAIT_RED;
      end
      S_WAIT_RED: begin
        if (w_red_entry) w_state_nxt = S_WALK;
      end
      S_WALK: begin
        if (!w_red)
          w_state_nxt = w_pend ? S_WAIT_RED : S_IDLE;
        else if (r_rem == 4'd0)
          w_state_nxt = S_FLASH;
      end
      S_FLASH: begin
        if (!w_red || r_rem == 4'd0)
          w_state_nxt = w_pend ? S_WAIT_RED : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Abort (light not red) wins over normal phase completion.
  always_comb begin
    w_walk_nxt  = 1'b0;
    w_dw_nxt    = 1'b1;
    w_rem_nxt   = 4'd0;
    w_abort_nxt = 1'b0;
    w_req_nxt   = r_req;
    w_fault_nxt = r_fault | ~w_legal;
    unique case (r_state)
      S_IDLE: begin
        w_req_nxt = w_pend;
      end
      S_WAIT_RED: begin
        w_req_nxt = ~w_red_entry;
        if (w_red_entry) begin
          w_walk_nxt = 1'b1;
          w_dw_nxt   = 1'b0;
          w_rem_nxt  = WALK_LAST;
        end
      end
      S_WALK: begin
        w_req_nxt = w_pend;
        if (!w_red) begin
          w_abort_nxt = 1'b1;
        end else if (r_rem == 4'd0) begin
          w_rem_nxt = FLASH_LAST;
        end else begin
          w_walk_nxt = 1'b1;
          w_dw_nxt   = 1'b0;
          w_rem_nxt  = r_rem - 4'd1;
        end
      end
      S_FLASH: begin
        w_req_nxt = w_pend;
        if (!w_red) begin
          w_abort_nxt = 1'b1;
        end else if (r_rem != 4'd0) begin
          w_dw_nxt  = ~r_dw;
          w_rem_nxt = r_rem - 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign walk        = r_walk;
  assign dont_walk   = r_dw;
  assign req_pending = r_req;
  assign remaining   = r_rem;
  assign abort       = r_abort;
  assign fault       = r_fault;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Bench for ped_signal_ctrl: directed scenarios plus random traffic,
// checked against a phase/elapsed-time reference model.
module tb_ped_signal_ctrl;

  localparam int         WC = 6;
  localparam int         FC = 4;
  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] G  = 3'b001;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] light;
  logic       ped_req;
  logic       walk;
  logic       dont_walk;
  logic       req_pending;
  logic [3:0] remaining;
  logic       abort;
  logic       fault;

  always #5 clk = ~clk;

  ped_signal_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .light      (light),
    .ped_req    (ped_req),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .remaining  (remaining),
    .abort      (abort),
    .fault      (fault)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: phase 0 idle, 1 waiting, 2 walking, 3 flashing; m_t = cycles in phase
  int         m_phase = 0;
  int         m_t     = 0;
  bit         m_pend  = 0;
  bit         m_fault = 0;
  bit         m_abort = 0;
  logic [2:0] m_prev  = R;

  function automatic logic [8:0] exp_vec();
    logic w;
    logic d;
    int   rem;
    w   = (m_phase == 2);
    d   = !w && (m_phase != 3 || (m_t % 2) == 0);
    rem = (m_phase == 2) ? WC - 1 - m_t :
          (m_phase == 3) ? FC - 1 - m_t : 0;
    return {w, d, m_pend, 4'(rem), m_abort, m_fault};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {walk, dont_walk, req_pending, remaining, abort, fault};
  endfunction

  task automatic model_step(input logic [2:0] l, input bit p, input bit r);
    bit red;
    bit entry;
    bit legal;
    if (r) begin
      m_phase = 0; m_t = 0; m_pend = 0;
      m_fault = 0; m_abort = 0; m_prev = R;
      return;
    end
    red   = (l == R);
    entry = red && (m_prev != R);
    legal = (l == R) || (l == Y) || (l == G);
    m_abort = 0;
    if (m_phase == 0) begin
      if (p) begin m_phase = 1; m_pend = 1; end
    end else if (m_phase == 1) begin
      if (entry) begin m_phase = 2; m_t = 0; m_pend = 0; end
    end else begin
      m_pend = m_pend | p;
      if (!red) begin
        m_abort = 1; m_phase = m_pend ? 1 : 0; m_t = 0;
      end else if (m_phase == 2 && m_t == WC - 1) begin
        m_phase = 3; m_t = 0;
      end else if (m_phase == 3 && m_t == FC - 1) begin
        m_phase = m_pend ? 1 : 0; m_t = 0;
      end else begin
        m_t++;
      end
    end
    if (!legal) m_fault = 1;
    m_prev = l;
  endtask

  task automatic tick(input logic [2:0] l, input bit p, input bit r);
    light = l; ped_req = p; reset = r;
    @(posedge clk);
    model_step(l, p, r);
    #1;
  endtask

  task automatic test_reset();
    tick(G, 1'b1, 1'b1);
    tick(R, 1'b1, 1'b1);
    n_chk++;
    if (obs_vec() !== 9'b0_1_0_0000_0_0)
      $display("FAIL reset_vals: got %b want %b", obs_vec(), 9'b010000000);
    else n_pass++;
    tick(R, 1'b0, 1'b0);
    n_chk++;
    if (walk !== 1'b0)
      $display("FAIL reset_red_no_entry: walk %b want 0", walk);
    else n_pass++;
  endtask

  task automatic test_walk_flash();
    logic [8:0] e;
    tick(G, 1'b0, 1'b0);
    tick(G, 1'b1, 1'b0);
    n_chk++;
    if (req_pending !== 1'b1)
      $display("FAIL s1_req_latch: req %b want 1", req_pending);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick(R, 1'b0, 1'b0);
      e[8]   = (i < WC);
      e[7]   = (i < WC) ? 1'b0 :
               (i < WC + FC) ? ((i - WC) % 2 == 0) : 1'b1;
      e[6]   = 1'b0;
      e[5:2] = (i < WC) ? 4'(WC - 1 - i) :
               (i < WC + FC) ? 4'(WC + FC - 1 - i) : 4'd0;
      e[1:0] = 2'b00;
      n_chk++;
      if (obs_vec() !== e || e !== exp_vec())
        $display("FAIL s1_seq[%0d]: got %b want %b model %b",
                 i, obs_vec(), e, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_mid_red();
    tick(R, 1'b0, 1'b0);
    tick(R, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick(R, 1'b0, 1'b0);
    n_chk++;
    if (walk !== 1'b0 || req_pending !== 1'b1 || obs_vec() !== exp_vec())
      $display("FAIL s2_no_walk_mid_red: got %b model %b",
               obs_vec(), exp_vec());
    else n_pass++;
    tick(G, 1'b0, 1'b0);
    tick(Y, 1'b0, 1'b0);
    tick(R, 1'b0, 1'b0);
    n_chk++;
    if (walk !== 1'b1 || remaining !== 4'(WC - 1) ||
        obs_vec() !== exp_vec())
      $display("FAIL s2_walk_at_entry: got %b model %b",
               obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_abort();
    tick(R, 1'b0, 1'b0);
    tick(R, 1'b0, 1'b0);
    tick(Y, 1'b0, 1'b0);
    n_chk++;
    if (obs_vec() !== 9'b0_1_0_0000_1_0 || obs_vec() !== exp_vec())
      $display("FAIL s3_abort: got %b want %b", obs_vec(), 9'b010000010);
    else n_pass++;
    tick(Y, 1'b0, 1'b0);
    n_chk++;
    if (obs_vec() !== 9'b0_1_0_0000_0_0 || obs_vec() !== exp_vec())
      $display("FAIL s3_abort_one_cycle: got %b want %b",
               obs_vec(), 9'b010000000);
    else n_pass++;
  endtask

  task automatic test_flash_req();
    tick(G, 1'b0, 1'b0);
    tick(G, 1'b1, 1'b0);
    tick(Y, 1'b0, 1'b0);
    for (int i = 0; i < WC + 1; i++) tick(R, 1'b0, 1'b0);
    tick(R, 1'b1, 1'b0);
    n_chk++;
    if (req_pending !== 1'b1 || dont_walk !== 1'b0 ||
        obs_vec() !== exp_vec())
      $display("FAIL s4_req_in_flash: got %b model %b",
               obs_vec(), exp_vec());
    else n_pass++;
    for (int i = 0; i < FC - 1; i++) tick(R, 1'b0, 1'b0);
    n_chk++;
    if (obs_vec() !== 9'b0_1_1_0000_0_0 || obs_vec() !== exp_vec())
      $display("FAIL s4_wait_after_flash: got %b want %b",
               obs_vec(), 9'b011000000);
    else n_pass++;
    for (int i = 0; i < 3; i++) tick(R, 1'b0, 1'b0);
    tick(G, 1'b0, 1'b0);
    tick(Y, 1'b0, 1'b0);
    n_chk++;
    if (walk !== 1'b0 || req_pending !== 1'b1)
      $display("FAIL s4_still_waiting: walk %b req %b want 0 1",
               walk, req_pending);
    else n_pass++;
    tick(R, 1'b0, 1'b0);
    n_chk++;
    if (walk !== 1'b1 || req_pending !== 1'b0 || obs_vec() !== exp_vec())
      $display("FAIL s4_served: got %b model %b", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_fault();
    tick(3'b110, 1'b0, 1'b0);
    n_chk++;
    if (fault !== 1'b1 || abort !== 1'b1 || walk !== 1'b0 ||
        obs_vec() !== exp_vec())
      $display("FAIL s5_fault_set: got %b model %b", obs_vec(), exp_vec());
    else n_pass++;
    for (int i = 0; i < 3; i++) tick(G, 1'b0, 1'b0);
    n_chk++;
    if (fault !== 1'b1)
      $display("FAIL s5_fault_sticky: fault %b want 1", fault);
    else n_pass++;
    tick(G, 1'b0, 1'b1);
    n_chk++;
    if (fault !== 1'b0)
      $display("FAIL s5_fault_cleared: fault %b want 0", fault);
    else n_pass++;
  endtask

  task automatic test_reset_walk();
    tick(G, 1'b1, 1'b0);
    tick(Y, 1'b0, 1'b0);
    tick(R, 1'b0, 1'b0);
    tick(R, 1'b1, 1'b0);
    tick(R, 1'b0, 1'b1);
    n_chk++;
    if (obs_vec() !== 9'b0_1_0_0000_0_0)
      $display("FAIL s6_reset_mid_walk: got %b want %b",
               obs_vec(), 9'b010000000);
    else n_pass++;
    for (int i = 0; i < 5; i++) tick(R, 1'b0, 1'b0);
    n_chk++;
    if (walk !== 1'b0 || obs_vec() !== exp_vec())
      $display("FAIL s6_no_restart: got %b model %b",
               obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_same_edge();
    tick(Y, 1'b0, 1'b0);
    tick(R, 1'b1, 1'b0);
    n_chk++;
    if (walk !== 1'b0 || req_pending !== 1'b1)
      $display("FAIL same_edge_latch: walk %b req %b want 0 1",
               walk, req_pending);
    else n_pass++;
    tick(R, 1'b0, 1'b0);
    tick(G, 1'b0, 1'b0);
    tick(Y, 1'b0, 1'b0);
    tick(R, 1'b0, 1'b0);
    n_chk++;
    if (walk !== 1'b1 || obs_vec() !== exp_vec())
      $display("FAIL same_edge_served: got %b model %b",
               obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0] l;
    bit         p;
    bit         r;
    int         bad;
    l   = R;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) >= 90) begin
        case ($urandom_range(0, 2))
          0:       l = R;
          1:       l = Y;
          default: l = G;
        endcase
      end
      if ($urandom_range(0, 299) == 0) l = 3'($urandom_range(0, 7));
      p = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 249) == 0);
      tick(l, p, r);
      n_chk++;
      if (obs_vec() !== exp_vec() || (walk && dont_walk)) begin
        if (bad < 10)
          $display("FAIL random[%0d]: got %b model %b", i,
                   obs_vec(), exp_vec());
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    light   = G;
    ped_req = 1'b0;
    reset   = 1'b1;
    test_reset();
    test_walk_flash();
    test_mid_red();
    test_abort();
    test_flash_req();
    test_fault();
    test_reset_walk();
    test_same_edge();
    tick(G, 1'b0, 1'b1);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
